frame_read_sequencer: RTL and testbench

//  Sequences pixel fetches from the byte-wide image memory (3 B/pixel, row-major) for one frame.

---
 rtl/frame_read_sequencer_pkg.sv | 17 +
 rtl/frame_read_sequencer_sync_delay_counter.sv | 35 +++
 rtl/frame_read_sequencer.sv | 151 +++++++++++++++
 tb/tb_frame_read_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_read_sequencer_pkg.sv
// Shared definitions for the frame read sequencer: FSM state encodings,
// pixel packing constant and a width helper.
package frame_read_sequencer_pkg;

  localparam logic [1:0] STATE_IDLE  = 2'b00;
  localparam logic [1:0] STATE_VSYNC = 2'b01;
  localparam logic [1:0] STATE_HSYNC = 2'b10;
  localparam logic [1:0] STATE_DATA  = 2'b11;

  localparam int unsigned BYTES_PER_PIXEL = 3;

  // $clog2 clamped to at least one bit so degenerate sizes still elaborate
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/frame_read_sequencer_sync_delay_counter.sv
// Loadable down-counter with a registered terminal-count flag; the flag is
// high while the count sits at zero.
module frame_read_sequencer_sync_delay_counter #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] load_val_i,
  input  logic                 dec_i,
  output logic                 tc_o
);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tc_o    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_o    <= (count_d == '0);
    end
  end

endmodule

// File: rtl/frame_read_sequencer.sv
// Frame read sequencer: VSYNC/HSYNC timing plus pixel-pair byte addresses,
// paced by pix_ready. Define BOTTOM_UP_EN for bottom-up image storage.
module frame_read_sequencer
  import frame_read_sequencer_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = 768,
  parameter int unsigned IMAGE_HEIGHT = 512,
  parameter int unsigned START_DELAY  = 100,
  parameter int unsigned HSYNC_DELAY  = 160,
  parameter int unsigned ADDR_WIDTH   = 21,
  localparam int unsigned ROW_WIDTH   = clog2_min1(IMAGE_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pix_ready,
  output logic                  vertical_Pulse,
  output logic                  horizontal_Pulse,
  output logic                  pix_valid,
  output logic [ADDR_WIDTH-1:0] pixel_Addr,
  output logic [ROW_WIDTH-1:0]  row_Index,
  output logic                  done_Flag
);

  localparam int unsigned COL_WIDTH = clog2_min1(IMAGE_WIDTH);
  localparam int unsigned DLY_MAX   = (START_DELAY > HSYNC_DELAY) ? START_DELAY : HSYNC_DELAY;
  localparam int unsigned CNT_WIDTH = clog2_min1(DLY_MAX);

  localparam logic [CNT_WIDTH-1:0]  VSYNC_LOAD = CNT_WIDTH'(START_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0]  HSYNC_LOAD = CNT_WIDTH'(HSYNC_DELAY - 1);
  localparam logic [COL_WIDTH-1:0]  COL_LAST   = COL_WIDTH'(IMAGE_WIDTH - 2);
  localparam logic [ROW_WIDTH-1:0]  ROW_LAST   = ROW_WIDTH'(IMAGE_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] PAIR_BYTES = ADDR_WIDTH'(2 * BYTES_PER_PIXEL);
  localparam logic [ADDR_WIDTH-1:0] ROW_BYTES  = ADDR_WIDTH'(64'(BYTES_PER_PIXEL) * 64'(IMAGE_WIDTH));
`ifdef BOTTOM_UP_EN
  // Display row 0 maps to the last stored row; each new row steps back one row
  localparam logic [ADDR_WIDTH-1:0] FIRST_BASE = ADDR_WIDTH'(64'(BYTES_PER_PIXEL) * 64'(IMAGE_WIDTH)
                                                             * 64'(IMAGE_HEIGHT - 1));
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP   = ADDR_WIDTH'(0) - ROW_BYTES;
`else
  localparam logic [ADDR_WIDTH-1:0] FIRST_BASE = '0;
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP   = ROW_BYTES;
`endif

  logic [1:0]            state_q, state_d;
  logic [COL_WIDTH-1:0]  col_q, col_d;
  logic [ROW_WIDTH-1:0]  row_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  done_d;
  logic                  dly_load, dly_dec, dly_tc;
  logic [CNT_WIDTH-1:0]  dly_load_val;

  frame_read_sequencer_sync_delay_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_sync_delay (
    .clk        (clk),
    .reset      (reset),
    .load_i     (dly_load),
    .load_val_i (dly_load_val),
    .dec_i      (dly_dec),
    .tc_o       (dly_tc)
  );

  // Next-state, counter and address sequencing
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_Index;
    addr_d       = pixel_Addr;
    base_d       = base_q;
    done_d       = 1'b0;
    dly_load     = 1'b0;
    dly_dec      = 1'b0;
    dly_load_val = VSYNC_LOAD;
    case (state_q)
      STATE_IDLE: begin
        if (start) begin
          state_d  = STATE_VSYNC;
          col_d    = '0;
          row_d    = '0;
          base_d   = FIRST_BASE;
          addr_d   = FIRST_BASE;
          dly_load = 1'b1;
        end
      end
      STATE_VSYNC: begin
        if (dly_tc) begin
          state_d      = STATE_HSYNC;
          dly_load     = 1'b1;
          dly_load_val = HSYNC_LOAD;
        end else begin
          dly_dec = 1'b1;
        end
      end
      STATE_HSYNC: begin
        if (dly_tc) begin
          state_d = STATE_DATA;
        end else begin
          dly_dec = 1'b1;
        end
      end
      STATE_DATA: begin
        if (pix_ready) begin
          if (col_q != COL_LAST) begin
            col_d  = col_q + COL_WIDTH'(2);
            addr_d = pixel_Addr + PAIR_BYTES;
          end else if (row_Index != ROW_LAST) begin
            state_d      = STATE_HSYNC;
            col_d        = '0;
            row_d        = row_Index + ROW_WIDTH'(1);
            base_d       = base_q + ROW_STEP;
            addr_d       = base_q + ROW_STEP;
            dly_load     = 1'b1;
            dly_load_val = HSYNC_LOAD;
          end else begin
            state_d = STATE_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  // Sync outputs are decoded from the next state so they align with the state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= STATE_IDLE;
      col_q            <= '0;
      row_Index        <= '0;
      pixel_Addr       <= '0;
      base_q           <= '0;
      done_Flag        <= 1'b0;
      vertical_Pulse   <= 1'b0;
      horizontal_Pulse <= 1'b0;
    end else begin
      state_q          <= state_d;
      col_q            <= col_d;
      row_Index        <= row_d;
      pixel_Addr       <= addr_d;
      base_q           <= base_d;
      done_Flag        <= done_d;
      vertical_Pulse   <= (state_d == STATE_VSYNC);
      horizontal_Pulse <= (state_d == STATE_DATA);
    end
  end

  assign pix_valid = horizontal_Pulse;

endmodule

// File: tb/tb_frame_read_sequencer.sv
// Directed bench for frame_read_sequencer at W=8, H=4, START_DELAY=4, HSYNC_DELAY=3.
// Expected addresses follow BOTTOM_UP_EN when the build defines it.
module tb_frame_read_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        pix_ready;
  logic        vertical_Pulse;
  logic        horizontal_Pulse;
  logic        pix_valid;
  logic [20:0] pixel_Addr;
  logic [1:0]  row_Index;
  logic        done_Flag;

  int cmp_count = 0;
  int err_count = 0;

  frame_read_sequencer #(
    .IMAGE_WIDTH  (8),
    .IMAGE_HEIGHT (4),
    .START_DELAY  (4),
    .HSYNC_DELAY  (3),
    .ADDR_WIDTH   (21)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .pix_ready        (pix_ready),
    .vertical_Pulse   (vertical_Pulse),
    .horizontal_Pulse (horizontal_Pulse),
    .pix_valid        (pix_valid),
    .pixel_Addr       (pixel_Addr),
    .row_Index        (row_Index),
    .done_Flag        (done_Flag)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] exp_addr(input int r, input int col);
    int mr;
`ifdef BOTTOM_UP_EN
    mr = 3 - r;
`else
    mr = r;
`endif
    return 21'(3 * (8 * mr + col));
  endfunction

  // Checks one frame cycle by cycle; cycle 1 is the first after the start edge.
  // pa/pb: cycles whose closing edge sees a stray start pulse.
  // chain: request the next frame in the done_Flag cycle and return after that edge.
  task automatic run_frame(input string tag, input int pa, input int pb,
                           input bit chain, input bit pre_started);
    int last;
    if (!pre_started) begin
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    last = chain ? 33 : 36;
    for (int c = 1; c <= last; c++) begin
      logic ev, eh, ed;
      logic [1:0]  er;
      logic [20:0] ea;
      @(negedge clk);
      ev = (c >= 1 && c <= 4);
      eh = 1'b0;
      ed = (c == 33);
      er = 2'd0;
      ea = '0;
      if (c >= 5 && c <= 32) begin
        er = 2'((c - 5) / 7);
        if ((c - 5) % 7 >= 3) begin
          eh = 1'b1;
          ea = exp_addr((c - 5) / 7, 2 * (((c - 5) % 7) - 3));
        end
      end
      cmp_count++;
      if (vertical_Pulse !== ev) begin
        err_count++;
        $display("FAIL %s vsync cycle %0d: got %b want %b", tag, c, vertical_Pulse, ev);
      end
      cmp_count++;
      if (horizontal_Pulse !== eh || pix_valid !== eh) begin
        err_count++;
        $display("FAIL %s hsync/valid cycle %0d: got %b/%b want %b", tag, c,
                 horizontal_Pulse, pix_valid, eh);
      end
      cmp_count++;
      if (done_Flag !== ed) begin
        err_count++;
        $display("FAIL %s done cycle %0d: got %b want %b", tag, c, done_Flag, ed);
      end
      if (c <= 32) begin
        cmp_count++;
        if (row_Index !== er) begin
          err_count++;
          $display("FAIL %s row cycle %0d: got %0d want %0d", tag, c, row_Index, er);
        end
      end
      if (eh) begin
        cmp_count++;
        if (pixel_Addr !== ea) begin
          err_count++;
          $display("FAIL %s addr cycle %0d: got %0d want %0d", tag, c, pixel_Addr, ea);
        end
      end
      start = (c == pa) || (c == pb) || (chain && c == 33);
    end
    if (chain) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp_count++;
    if ({vertical_Pulse, horizontal_Pulse, pix_valid, done_Flag} !== 4'b0 ||
        pixel_Addr !== '0 || row_Index !== '0) begin
      err_count++;
      $display("FAIL reset outputs: got v%b h%b pv%b d%b a%0d r%0d want all 0",
               vertical_Pulse, horizontal_Pulse, pix_valid, done_Flag, pixel_Addr, row_Index);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    cmp_count++;
    if (vertical_Pulse !== 1'b0 || horizontal_Pulse !== 1'b0) begin
      err_count++;
      $display("FAIL idle_no_start: got v%b h%b want 0 0", vertical_Pulse, horizontal_Pulse);
    end
  endtask

  task automatic test_frame();
    run_frame("frame", 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_start();
    @(negedge clk);
    run_frame("ignore_start", 6, 10, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    run_frame("b2b_first", 0, 0, 1'b1, 1'b0);
    run_frame("b2b_second", 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_stall();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    cmp_count++;
    if (pixel_Addr !== exp_addr(0, 2) || pix_valid !== 1'b1) begin
      err_count++;
      $display("FAIL stall_pre: got a%0d pv%b want a%0d pv1", pixel_Addr, pix_valid, exp_addr(0, 2));
    end
    pix_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmp_count++;
      if (pixel_Addr !== exp_addr(0, 2) || pix_valid !== 1'b1) begin
        err_count++;
        $display("FAIL stall_hold %0d: got a%0d pv%b want a%0d pv1", i, pixel_Addr, pix_valid,
                 exp_addr(0, 2));
      end
    end
    pix_ready = 1'b1;
    @(negedge clk);
    cmp_count++;
    if (pixel_Addr !== exp_addr(0, 4) || pix_valid !== 1'b1) begin
      err_count++;
      $display("FAIL stall_resume: got a%0d pv%b want a%0d pv1", pixel_Addr, pix_valid, exp_addr(0, 4));
    end
    // observed cycle 15 now; done moves from cycle 33 to 38
    for (int c = 16; c <= 40; c++) begin
      @(negedge clk);
      cmp_count++;
      if (done_Flag !== (c == 38)) begin
        err_count++;
        $display("FAIL stall_done cycle %0d: got %b want %b", c, done_Flag, (c == 38));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    cmp_count++;
    if (horizontal_Pulse !== 1'b1) begin
      err_count++;
      $display("FAIL midreset_pre: got h%b want 1", horizontal_Pulse);
    end
    reset = 1'b1;
    #1;
    cmp_count++;
    if ({vertical_Pulse, horizontal_Pulse, pix_valid, done_Flag} !== 4'b0 ||
        pixel_Addr !== '0 || row_Index !== '0) begin
      err_count++;
      $display("FAIL midreset_async: got v%b h%b pv%b d%b a%0d r%0d want all 0",
               vertical_Pulse, horizontal_Pulse, pix_valid, done_Flag, pixel_Addr, row_Index);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cmp_count++;
    if (horizontal_Pulse !== 1'b0 || vertical_Pulse !== 1'b0) begin
      err_count++;
      $display("FAIL midreset_idle: got v%b h%b want 0 0", vertical_Pulse, horizontal_Pulse);
    end
    run_frame("after_reset", 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame();
    test_ignore_start();
    test_back_to_back();
    test_stall();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
